// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: handshake and PC-control signals between the PC sequencer and the core
interface pc_seq_ctrl_if;
    logic        mem_ready;
    logic        dec_valid;
    logic [1:0]  dec_ext_words;
    logic [1:0]  dec_kind;
    logic        jump_taken;
    logic        exec_done;
    logic        irq;
    logic [3:0]  irq_id;
    logic        gie;
    logic [2:0]  pc_sel;
    logic        pc_we;
    logic        mem_req;
    logic        mab_pc;
    logic [15:0] vec_addr;
    logic        ir_load;
    logic        ext_load;
    logic        irq_ack;
    logic [2:0]  state_dbg;

    modport master (
        input  mem_ready, dec_valid, dec_ext_words, dec_kind, jump_taken,
               exec_done, irq, irq_id, gie,
        output pc_sel, pc_we, mem_req, mab_pc, vec_addr, ir_load, ext_load,
               irq_ack, state_dbg
    );

    modport slave (
        output mem_ready, dec_valid, dec_ext_words, dec_kind, jump_taken,
               exec_done, irq, irq_id, gie,
        input  pc_sel, pc_we, mem_req, mab_pc, vec_addr, ir_load, ext_load,
               irq_ack, state_dbg
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: MSP430 program-counter sequencer driving the PC mux, PC write enable and fetch handshakes
module pc_seq_ctrl #(
    parameter logic [15:0] RESET_VEC = 16'hFFFE,
    parameter logic [15:0] IRQ_BASE  = 16'hFFE0
) (
    input logic          clk,
    input logic          rst_n,
    pc_seq_ctrl_if.master bus
);
    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_VEC    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXT    = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_IRQ    = 3'd6;

    logic [2:0]  state, state_nxt;
    logic [1:0]  ext_cnt, kind;
    logic [15:0] vec_addr_q;
    logic [2:0]  pc_sel;
    logic        pc_we, mem_req, mab_pc, ir_load, ext_load, irq_ack;

    // Next state and Mealy outputs; PC writes happen only in the cycle a handshake completes
    always_comb begin
        state_nxt = state;
        pc_sel    = 3'd1;
        pc_we     = 1'b0;
        mem_req   = 1'b0;
        mab_pc    = 1'b1;
        ir_load   = 1'b0;
        ext_load  = 1'b0;
        irq_ack   = 1'b0;
        case (state)
            S_RST: state_nxt = S_VEC;
            S_VEC: begin
                mem_req = 1'b1;
                mab_pc  = 1'b0;
                if (bus.mem_ready) begin
                    pc_sel    = 3'd4;
                    pc_we     = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_load   = 1'b1;
                    pc_sel    = 3'd0;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.dec_valid)
                    state_nxt = (bus.dec_ext_words != 2'd0) ? S_EXT : S_EXEC;
            end
            S_EXT: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ext_load  = 1'b1;
                    pc_sel    = 3'd0;
                    pc_we     = 1'b1;
                    state_nxt = (ext_cnt <= 2'd1) ? S_EXEC : S_EXT;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    case (kind)
                        2'd1: begin
                            pc_sel = bus.jump_taken ? 3'd2 : 3'd1;
                            pc_we  = bus.jump_taken;
                        end
                        2'd2: begin
                            pc_sel = 3'd4;
                            pc_we  = 1'b1;
                        end
                        2'd3: begin
                            pc_sel = 3'd3;
                            pc_we  = 1'b1;
                        end
                        default: ;
                    endcase
                    state_nxt = (bus.irq && bus.gie) ? S_IRQ : S_FETCH;
                end
            end
            S_IRQ: begin
                irq_ack   = 1'b1;
                state_nxt = S_VEC;
            end
            default: state_nxt = S_RST;
        endcase
    end

    // State, latched decode info and vector address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RST;
            ext_cnt    <= 2'd0;
            kind       <= 2'd0;
            vec_addr_q <= RESET_VEC;
        end else begin
            state <= state_nxt;
            if (state == S_RST)
                vec_addr_q <= RESET_VEC;
            if (state == S_DECODE && bus.dec_valid) begin
                ext_cnt <= (bus.dec_ext_words == 2'd3) ? 2'd2 : bus.dec_ext_words;
                kind    <= bus.dec_kind;
            end
            if (state == S_EXT && bus.mem_ready)
                ext_cnt <= ext_cnt - 2'd1;
            if (state == S_IRQ)
                vec_addr_q <= IRQ_BASE + {11'd0, bus.irq_id, 1'b0};
        end
    end

    assign bus.pc_sel    = pc_sel;
    assign bus.pc_we     = pc_we;
    assign bus.mem_req   = mem_req;
    assign bus.mab_pc    = mab_pc;
    assign bus.ir_load   = ir_load;
    assign bus.ext_load  = ext_load;
    assign bus.irq_ack   = irq_ack;
    assign bus.vec_addr  = vec_addr_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: randomized lockstep stimulus with a scoreboard of expected PC writes and strobes
module tb_pc_seq_ctrl;
    localparam logic [15:0] RV = 16'hFFFE;
    localparam logic [15:0] IB = 16'hFFE0;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic [2:0]  sel;
        logic [3:0]  strobes;
        logic [15:0] val;
        logic        cv;
        logic [15:0] vec;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_exec = 1'b0;
    logic [15:0] pc = 16'h0, mdb, mdb_x, calc, mpc, pc_nxt;
    int tests = 0, fails = 0, cyc = 0;
    ev_t q[$];

    always #5 clk = ~clk;

    pc_seq_ctrl_if bus();
    pc_seq_ctrl #(.RESET_VEC(RV), .IRQ_BASE(IB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'h3FFE;
    endfunction

    assign mdb = in_exec ? mdb_x : mem_fn(bus.mab_pc ? pc : bus.vec_addr);

    // Core datapath model: the PC mux the sequencer steers
    always_comb begin
        pc_nxt = pc;
        case (bus.pc_sel)
            3'd0: pc_nxt = (pc + 16'd2) & 16'hFFFE;
            3'd2: pc_nxt = calc;
            3'd3: pc_nxt = mdb << 1;
            3'd4: pc_nxt = mdb;
            default: ;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.pc_we) pc <= pc_nxt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes PC or pulses a strobe
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.pc_we) chk("hold_sel", {29'd0, bus.pc_sel}, 32'd1);
            else chk("we_sel_legal", {31'd0, bus.pc_sel inside {3'd0, 3'd2, 3'd3, 3'd4}}, 32'd1);
            if (bus.pc_we || bus.ir_load || bus.ext_load || bus.irq_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {28'd0, bus.pc_we, bus.ir_load, bus.ext_load, bus.irq_ack}, 32'd0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_state", {29'd0, bus.state_dbg}, {29'd0, e.st});
                    chk("event_strobes", {28'd0, bus.pc_we, bus.ir_load, bus.ext_load, bus.irq_ack}, {28'd0, e.strobes});
                    if (e.strobes[3]) begin
                        chk("pc_sel", {29'd0, bus.pc_sel}, {29'd0, e.sel});
                        chk("pc_value", {16'd0, pc_nxt}, {16'd0, e.val});
                    end
                    if (e.cv) chk("vec_addr", {16'd0, bus.vec_addr}, {16'd0, e.vec});
                end
            end
        end
    end

    function automatic void push(input logic [2:0] st, input logic [2:0] sel, input logic [3:0] stb,
                                 input logic [15:0] val, input logic cv, input logic [15:0] vec);
        ev_t e;
        e = '{cyc, st, sel, stb, val, cv, vec};
        q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        bus.mem_ready     = 1'($urandom);
        bus.dec_valid     = 1'($urandom);
        bus.dec_ext_words = 2'($urandom);
        bus.dec_kind      = 2'($urandom);
        bus.jump_taken    = 1'($urandom);
        bus.exec_done     = 1'($urandom);
        bus.irq           = 1'($urandom);
        bus.irq_id        = 4'($urandom);
        bus.gie           = 1'($urandom);
        calc              = 16'($urandom);
        mdb_x             = 16'($urandom);
    endtask

    task automatic rst_chk();
        chk("rst_pc_sel", {29'd0, bus.pc_sel}, 32'd1);
        chk("rst_ctrl", {27'd0, bus.pc_we, bus.mem_req, bus.ir_load, bus.ext_load, bus.irq_ack}, 32'd0);
        chk("rst_mab_pc", {31'd0, bus.mab_pc}, 32'd1);
        chk("rst_state", {29'd0, bus.state_dbg}, 32'd0);
        chk("rst_vec_addr", {16'd0, bus.vec_addr}, {16'd0, RV});
    endtask

    task automatic vec_ph(input logic [15:0] a);
        in_exec = 1'b0;
        repeat ($urandom_range(0, 2)) begin noise(); bus.mem_ready = 1'b0; tick(); end
        noise();
        bus.mem_ready = 1'b1;
        mpc = mem_fn(a);
        push(3'd1, 3'd4, 4'b1000, mpc, 1'b1, a);
        tick();
    endtask

    task automatic fetch_ph();
        in_exec = 1'b0;
        repeat ($urandom_range(0, 2)) begin noise(); bus.mem_ready = 1'b0; tick(); end
        noise();
        bus.mem_ready = 1'b1;
        mpc = (mpc + 16'd2) & 16'hFFFE;
        push(3'd2, 3'd0, 4'b1100, mpc, 1'b0, 16'd0);
        tick();
    endtask

    task automatic decode_ph(input int w_force, output int n, output int k);
        int w;
        repeat ($urandom_range(0, 2)) begin noise(); bus.dec_valid = 1'b0; tick(); end
        noise();
        bus.dec_valid = 1'b1;
        w = (w_force < 0) ? int'($urandom_range(0, 3)) : w_force;
        k = int'($urandom_range(0, 3));
        bus.dec_ext_words = 2'(w);
        bus.dec_kind = 2'(k);
        n = (w > 2) ? 2 : w;
        tick();
    endtask

    task automatic ext_ph();
        repeat ($urandom_range(0, 2)) begin noise(); bus.mem_ready = 1'b0; tick(); end
        noise();
        bus.mem_ready = 1'b1;
        mpc = (mpc + 16'd2) & 16'hFFFE;
        push(3'd4, 3'd0, 4'b1010, mpc, 1'b0, 16'd0);
        tick();
    endtask

    task automatic exec_ph(input int k, output logic take);
        in_exec = 1'b1;
        repeat ($urandom_range(0, 3)) begin noise(); bus.exec_done = 1'b0; tick(); end
        noise();
        bus.exec_done = 1'b1;
        if (k == 1 && bus.jump_taken) begin mpc = calc; push(3'd5, 3'd2, 4'b1000, mpc, 1'b0, 16'd0); end
        if (k == 2) begin mpc = mdb_x; push(3'd5, 3'd4, 4'b1000, mpc, 1'b0, 16'd0); end
        if (k == 3) begin mpc = mdb_x << 1; push(3'd5, 3'd3, 4'b1000, mpc, 1'b0, 16'd0); end
        take = bus.irq && bus.gie;
        tick();
        in_exec = 1'b0;
    endtask

    task automatic irq_ph();
        logic [3:0] id;
        noise();
        id = 4'($urandom);
        bus.irq_id = id;
        push(3'd6, 3'd1, 4'b0001, 16'd0, 1'b0, 16'd0);
        tick();
        vec_ph(IB + {11'd0, id, 1'b0});
    endtask

    task automatic instr();
        int n, k;
        logic take;
        fetch_ph();
        decode_ph(-1, n, k);
        repeat (n) ext_ph();
        exec_ph(k, take);
        if (take) irq_ph();
    endtask

    task automatic boot();
        noise();
        rst_n = 1'b1;
        tick();
        vec_ph(RV);
    endtask

    initial begin
        int n, k;
        noise();
        repeat (3) @(posedge clk);
        #1;
        rst_chk();
        boot();
        repeat (50) instr();
        fetch_ph();
        decode_ph(2, n, k);
        noise();
        bus.mem_ready = 1'b1;
        chk("ext_req_high", {31'd0, bus.mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk();
        repeat (2) tick();
        rst_chk();
        boot();
        repeat (50) instr();
        noise();
        bus.mem_ready = 1'b0;
        bus.exec_done = 1'b0;
        repeat (3) tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
